// File: rtl/round_sequencer_pkg.sv
// Shared types and default timing for the round sequencer and the display path.
package round_sequencer_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EVAL    = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam int ROUND_W            = 8;
    localparam int DEF_HOLD_CYCLES    = 10_000_000;
    localparam int DEF_TIMEOUT_CYCLES = 50_000_000;
    localparam int DEF_CNT_W          = 26;

endpackage

// File: rtl/round_sequencer_if.sv
// Button inputs and strobe/status outputs of the round sequencer.
interface round_sequencer_if;
    import round_sequencer_pkg::*;

    // Buttons are levels; roll/eval/timeout are single-cycle strobes with no
    // back-pressure: a consumer must act on the cycle a strobe is high.
    logic               btn1;
    logic               btn2;
    logic               roll1_o;
    logic               roll2_o;
    logic               eval_o;
    logic               wait1_o;
    logic               wait2_o;
    logic               hold_o;
    logic               timeout_o;
    logic [ROUND_W-1:0] round_cnt_o;
    state_t             state_o;

    modport master (
        output btn1, btn2,
        input  roll1_o, roll2_o, eval_o, wait1_o, wait2_o, hold_o, timeout_o,
        input  round_cnt_o, state_o
    );

    modport slave (
        input  btn1, btn2,
        output roll1_o, roll2_o, eval_o, wait1_o, wait2_o, hold_o, timeout_o,
        output round_cnt_o, state_o
    );

endinterface

// File: rtl/round_sequencer_btn_edge.sv
// Rising-edge detector: press is high in the first cycle a level input is high.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= btn;
        end
    end

    assign press = btn & ~prev;

endmodule

// File: rtl/round_sequencer.sv
// Game-round controller: collects one roll per player, strobes evaluation,
// holds the display for a fixed time and aborts half-finished rounds.
module round_sequencer
    import round_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    round_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);

    logic               press1;
    logic               press2;
    logic               new1;
    logic               new2;
    state_t             state;
    logic               acc1;
    logic               acc2;
    logic [CNT_W-1:0]   cnt;
    logic               roll1_q;
    logic               roll2_q;
    logic               eval_q;
    logic               wait1_q;
    logic               wait2_q;
    logic               hold_q;
    logic               timeout_q;
    logic [ROUND_W-1:0] round_q;

    btn_edge u_edge1 (.clk(clk), .rst_n(rst_n), .btn(bus.btn1), .press(press1));
    btn_edge u_edge2 (.clk(clk), .rst_n(rst_n), .btn(bus.btn2), .press(press2));

    assign new1 = press1 & ~acc1;
    assign new2 = press2 & ~acc2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            acc1      <= 1'b0;
            acc2      <= 1'b0;
            cnt       <= '0;
            roll1_q   <= 1'b0;
            roll2_q   <= 1'b0;
            eval_q    <= 1'b0;
            wait1_q   <= 1'b1;
            wait2_q   <= 1'b1;
            hold_q    <= 1'b0;
            timeout_q <= 1'b0;
            round_q   <= '0;
        end else begin
            roll1_q   <= 1'b0;
            roll2_q   <= 1'b0;
            eval_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                COLLECT: begin
                    if (acc1 && acc2) begin
                        state   <= EVAL;
                        eval_q  <= 1'b1;
                        hold_q  <= 1'b1;
                        round_q <= round_q + ROUND_W'(1);
                        acc1    <= 1'b0;
                        acc2    <= 1'b0;
                        cnt     <= '0;
                    end else begin
                        roll1_q <= new1;
                        roll2_q <= new2;
                        if (new1) begin
                            acc1    <= 1'b1;
                            wait1_q <= 1'b0;
                        end
                        if (new2) begin
                            acc2    <= 1'b1;
                            wait2_q <= 1'b0;
                        end
                        // A late press on the expiry cycle completes the round
                        // instead of aborting it.
                        if (acc1 ^ acc2) begin
                            if (new1 || new2) begin
                                cnt <= '0;
                            end else if (cnt == TIMEOUT_LAST) begin
                                timeout_q <= 1'b1;
                                acc1      <= 1'b0;
                                acc2      <= 1'b0;
                                wait1_q   <= 1'b1;
                                wait2_q   <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                EVAL: begin
                    state <= SHOW;
                    cnt   <= '0;
                end
                SHOW: begin
                    if (cnt == HOLD_LAST) begin
                        state   <= COLLECT;
                        hold_q  <= 1'b0;
                        wait1_q <= 1'b1;
                        wait2_q <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

    assign bus.roll1_o     = roll1_q;
    assign bus.roll2_o     = roll2_q;
    assign bus.eval_o      = eval_q;
    assign bus.wait1_o     = wait1_q;
    assign bus.wait2_o     = wait2_q;
    assign bus.hold_o      = hold_q;
    assign bus.timeout_o   = timeout_q;
    assign bus.round_cnt_o = round_q;
    assign bus.state_o     = state;

endmodule

// File: tb/tb_round_sequencer.sv
// Directed bench for round_sequencer with an event-level reference model.
module tb_round_sequencer;
    import round_sequencer_pkg::*;

    localparam int HOLD = 4;
    localparam int TMO  = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    round_sequencer_if bus();

    round_sequencer #(
        .HOLD_CYCLES   (HOLD),
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected output vector: {roll1, roll2, eval, wait1, wait2, hold, timeout, round[7:0]}
    logic [14:0] exp_q[$];
    logic h1, h2, got1, got2, m_wait1, m_wait2, m_hold;
    int   busy, first_at, ecount, m_round;

    task automatic model_reset();
        h1 = 0; h2 = 0; got1 = 0; got2 = 0;
        busy = 0; first_at = 0; ecount = 0;
        m_wait1 = 1; m_wait2 = 1; m_hold = 0; m_round = 0;
    endtask

    task automatic model_step(input logic b1, input logic b2);
        logic p1, p2, n1, n2, r1, r2, ev, to;
        p1 = b1 && !h1;
        p2 = b2 && !h2;
        h1 = b1;
        h2 = b2;
        ecount++;
        r1 = 0; r2 = 0; ev = 0; to = 0;
        if (busy > 0) begin
            // evaluate cycle plus display hold: inputs ignored
            busy--;
            if (busy == 0) begin
                m_hold = 0; m_wait1 = 1; m_wait2 = 1;
            end
        end else if (got1 && got2) begin
            ev = 1; m_hold = 1;
            m_round = (m_round + 1) % 256;
            got1 = 0; got2 = 0;
            busy = HOLD + 1;
        end else begin
            n1 = p1 && !got1;
            n2 = p2 && !got2;
            if (!got1 && !got2 && (n1 || n2)) first_at = ecount;
            if ((got1 != got2) && !n1 && !n2 && (ecount - first_at == TMO)) begin
                to = 1; got1 = 0; got2 = 0;
            end else begin
                if (n1) begin got1 = 1; r1 = 1; end
                if (n2) begin got2 = 1; r2 = 1; end
            end
            m_wait1 = !got1;
            m_wait2 = !got2;
        end
        exp_q.push_back({r1, r2, ev, m_wait1, m_wait2, m_hold, to, 8'(m_round)});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
                exp_q.delete();
                exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});
            end else begin
                model_step(bus.btn1, bus.btn2);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [14:0] e;
        if (exp_q.size() == 0) begin
            chk("exp_queue_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("roll1_o",     int'(bus.roll1_o),     int'(e[14]));
            chk("roll2_o",     int'(bus.roll2_o),     int'(e[13]));
            chk("eval_o",      int'(bus.eval_o),      int'(e[12]));
            chk("wait1_o",     int'(bus.wait1_o),     int'(e[11]));
            chk("wait2_o",     int'(bus.wait2_o),     int'(e[10]));
            chk("hold_o",      int'(bus.hold_o),      int'(e[9]));
            chk("timeout_o",   int'(bus.timeout_o),   int'(e[8]));
            chk("round_cnt_o", int'(bus.round_cnt_o), int'(e[7:0]));
        end
    end

    // strobe pulse counters for "exactly one" style checks
    int n_roll1 = 0, n_roll2 = 0, n_eval = 0;
    always @(negedge clk) begin
        if (bus.roll1_o) n_roll1++;
        if (bus.roll2_o) n_roll2++;
        if (bus.eval_o)  n_eval++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic goto(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s1, s2;
        bus.btn1 = 1'b0;
        bus.btn2 = 1'b0;

        // basic round: btn1 at 5, btn2 at 9
        do_reset();
        chk("rst_wait1", int'(bus.wait1_o), 1);
        chk("rst_round", int'(bus.round_cnt_o), 0);
        chk("rst_state", int'(bus.state_o), int'(COLLECT));
        goto(5);  bus.btn1 = 1'b1;
        goto(6);  chk("t1_roll1_c6", int'(bus.roll1_o), 1);
                  chk("t1_wait1_c6", int'(bus.wait1_o), 0);
        goto(7);  chk("t1_roll1_c7", int'(bus.roll1_o), 0); bus.btn1 = 1'b0;
        goto(9);  bus.btn2 = 1'b1;
        goto(10); chk("t1_roll2_c10", int'(bus.roll2_o), 1);
        goto(11); chk("t1_eval_c11", int'(bus.eval_o), 1);
                  chk("t1_hold_c11", int'(bus.hold_o), 1);
                  chk("t1_round_c11", int'(bus.round_cnt_o), 1);
                  bus.btn2 = 1'b0;
        goto(12); chk("t1_eval_c12", int'(bus.eval_o), 0);
        goto(15); chk("t1_hold_c15", int'(bus.hold_o), 1);
                  chk("t1_wait2_c15", int'(bus.wait2_o), 0);
        goto(16); chk("t1_hold_c16", int'(bus.hold_o), 0);
                  chk("t1_wait1_c16", int'(bus.wait1_o), 1);
                  chk("t1_wait2_c16", int'(bus.wait2_o), 1);

        // simultaneous presses at 3
        do_reset();
        goto(3);  bus.btn1 = 1'b1; bus.btn2 = 1'b1;
        goto(4);  chk("t2_roll1_c4", int'(bus.roll1_o), 1);
                  chk("t2_roll2_c4", int'(bus.roll2_o), 1);
                  bus.btn1 = 1'b0; bus.btn2 = 1'b0;
        goto(5);  chk("t2_eval_c5", int'(bus.eval_o), 1);

        // btn1 pressed three times before btn2
        do_reset();
        s1 = n_roll1;
        goto(2);  bus.btn1 = 1'b1;
        goto(3);  chk("t3_roll1_c3", int'(bus.roll1_o), 1); bus.btn1 = 1'b0;
        goto(4);  bus.btn1 = 1'b1;
        goto(5);  chk("t3_roll1_c5", int'(bus.roll1_o), 0); bus.btn1 = 1'b0;
        goto(6);  bus.btn1 = 1'b1;
        goto(7);  chk("t3_roll1_c7", int'(bus.roll1_o), 0); bus.btn1 = 1'b0;
        goto(8);  chk("t3_wait1_c8", int'(bus.wait1_o), 0);
        goto(9);  bus.btn2 = 1'b1;
        goto(10); chk("t3_roll2_c10", int'(bus.roll2_o), 1); bus.btn2 = 1'b0;
        goto(11); chk("t3_eval_c11", int'(bus.eval_o), 1);
        goto(15); chk("t3_wait1_c15", int'(bus.wait1_o), 0);
        goto(16); chk("t3_wait1_c16", int'(bus.wait1_o), 1);
                  chk("t3_roll1_count", n_roll1 - s1, 1);

        // timeout: btn1 at 2, nothing from player 2
        do_reset();
        goto(2);  bus.btn1 = 1'b1;
        goto(3);  bus.btn1 = 1'b0;
        goto(22); chk("t4_timeout_c22", int'(bus.timeout_o), 0);
                  chk("t4_wait1_c22", int'(bus.wait1_o), 0);
        goto(23); chk("t4_timeout_c23", int'(bus.timeout_o), 1);
                  chk("t4_wait1_c23", int'(bus.wait1_o), 1);
        goto(24); chk("t4_timeout_c24", int'(bus.timeout_o), 0);
                  chk("t4_round_c24", int'(bus.round_cnt_o), 0);
        s2 = n_eval;
        goto(26); bus.btn2 = 1'b1;
        goto(27); chk("t4_roll2_c27", int'(bus.roll2_o), 1);
                  chk("t4_wait2_c27", int'(bus.wait2_o), 0);
                  bus.btn2 = 1'b0;
        goto(30); chk("t4_no_eval", n_eval - s2, 0);

        // missing press lands on the expiry cycle
        do_reset();
        goto(2);  bus.btn1 = 1'b1;
        goto(3);  bus.btn1 = 1'b0;
        goto(22); bus.btn2 = 1'b1;
        goto(23); chk("t5_roll2_c23", int'(bus.roll2_o), 1);
                  chk("t5_timeout_c23", int'(bus.timeout_o), 0);
                  bus.btn2 = 1'b0;
        goto(24); chk("t5_eval_c24", int'(bus.eval_o), 1);
                  chk("t5_timeout_c24", int'(bus.timeout_o), 0);
                  chk("t5_round_c24", int'(bus.round_cnt_o), 1);

        // buttons held through SHOW, then reset mid-SHOW
        do_reset();
        goto(2);  bus.btn1 = 1'b1;
        goto(4);  bus.btn2 = 1'b1;
        goto(6);  chk("t6_eval_c6", int'(bus.eval_o), 1);
                  chk("t6_round_c6", int'(bus.round_cnt_o), 1);
        goto(7);  s1 = n_roll1; s2 = n_roll2;
        goto(11); chk("t6_hold_c11", int'(bus.hold_o), 0);
                  chk("t6_wait1_c11", int'(bus.wait1_o), 1);
        goto(13); chk("t6_held_roll1", n_roll1 - s1, 0);
                  chk("t6_held_roll2", n_roll2 - s2, 0);
                  bus.btn1 = 1'b0; bus.btn2 = 1'b0;
        goto(14); bus.btn1 = 1'b1;
        goto(15); bus.btn2 = 1'b1;
        goto(17); chk("t6_eval_c17", int'(bus.eval_o), 1);
                  chk("t6_round_c17", int'(bus.round_cnt_o), 2);
        goto(19); rst_n = 1'b0;
        #1;       chk("t6_async_hold", int'(bus.hold_o), 0);
                  chk("t6_async_round", int'(bus.round_cnt_o), 0);
                  chk("t6_async_wait2", int'(bus.wait2_o), 1);
        bus.btn1 = 1'b0; bus.btn2 = 1'b0;
        tick(); tick();
        rst_n = 1'b1; cyc = 0;
        s1 = n_roll1; s2 = n_eval;
        goto(6);  chk("t6_post_round", int'(bus.round_cnt_o), 0);
                  chk("t6_post_wait1", int'(bus.wait1_o), 1);
                  chk("t6_post_rolls", n_roll1 - s1, 0);
                  chk("t6_post_eval", n_eval - s2, 0);

        // 256 completed rounds wrap the round counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 1) begin
                bus.btn2 = 1'b1; tick();
                bus.btn2 = 1'b0; bus.btn1 = 1'b1; tick();
                bus.btn1 = 1'b0;
                repeat (7) tick();
            end else begin
                bus.btn1 = 1'b1; bus.btn2 = 1'b1; tick();
                bus.btn1 = 1'b0; bus.btn2 = 1'b0;
                repeat (8) tick();
            end
            if (i == 254) chk("t7_round_255", int'(bus.round_cnt_o), 255);
        end
        chk("t7_round_wrap", int'(bus.round_cnt_o), 0);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: got time %0t want finish before it", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
